// File: rtl/mcycle_ctrl_ws.sv
// Multicycle processor control FSM with optional extended opcodes, an illegal-opcode
// trap, and cycle/retired-instruction counters.
module mcycle_ctrl_ws #(
  parameter int unsigned CNT_W           = 32,
  parameter bit          EN_EXT          = 1'b1,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             memrdy,
  output logic             memreq,
  output logic             pcen,
  output logic             irwrite,
  output logic             memwrite,
  output logic             regwrite,
  output logic             alusrca,
  output logic             iord,
  output logic [1:0]       regdst,
  output logic [1:0]       wdsel,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic             zeroext,
  output logic [2:0]       aluop,
  output logic             illegal,
  output logic [CNT_W-1:0] cyclecnt,
  output logic [CNT_W-1:0] instrcnt
);

  // state   | meaning
  // FETCH   | read instruction, PC+4 ; DECODE | register read, branch target
  // MEMADR  | lw/sw address           ; MEMRD/MEMWB | load access / writeback
  // MEMWR   | store access            ; RTYPEEX/RTYPEWB | R-type execute / writeback
  // BEQEX/BNEEX | branch resolve      ; ADDIEX/ANDIEX/ORIEX | immediate execute
  // IMMWB   | immediate writeback     ; JEX/JALEX | jump / jump-and-link
  // HALT    | stopped after illegal opcode, left only by reset
  typedef enum logic [4:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, BNEEX,
    ADDIEX, ANDIEX, ORIEX, IMMWB, JEX, JALEX, HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t state, state_nxt;
  logic   bad_op;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= FETCH;
      illegal  <= 1'b0;
      cyclecnt <= '0;
      instrcnt <= '0;
    end else begin
      state <= state_nxt;
      if (bad_op) illegal <= 1'b1;
      if (state != HALT) cyclecnt <= cyclecnt + CNT_W'(1);
      if (state_nxt == FETCH && state != FETCH) instrcnt <= instrcnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    bad_op    = 1'b0;
    memreq    = 1'b0;
    pcen      = 1'b0;
    irwrite   = 1'b0;
    memwrite  = 1'b0;
    regwrite  = 1'b0;
    alusrca   = 1'b0;
    iord      = 1'b0;
    regdst    = 2'b00;
    wdsel     = 2'b00;
    alusrcb   = 2'b00;
    pcsrc     = 2'b00;
    zeroext   = 1'b0;
    aluop     = 3'b000;
    case (state)
      FETCH: begin
        memreq  = 1'b1;
        alusrcb = 2'b01;
        irwrite = memrdy;
        pcen    = memrdy;
        if (memrdy) state_nxt = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYPE:     state_nxt = RTYPEEX;
          OP_BEQ:       state_nxt = BEQEX;
          OP_ADDI:      state_nxt = ADDIEX;
          OP_J:         state_nxt = JEX;
          OP_BNE:       if (EN_EXT) state_nxt = BNEEX;  else bad_op = 1'b1;
          OP_ANDI:      if (EN_EXT) state_nxt = ANDIEX; else bad_op = 1'b1;
          OP_ORI:       if (EN_EXT) state_nxt = ORIEX;  else bad_op = 1'b1;
          OP_JAL:       if (EN_EXT) state_nxt = JALEX;  else bad_op = 1'b1;
          default:      bad_op = 1'b1;
        endcase
        // A non-halting illegal opcode retires as a no-op through FETCH.
        if (bad_op) state_nxt = HALT_ON_ILLEGAL ? HALT : FETCH;
      end
      MEMADR: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        state_nxt = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        memreq = 1'b1;
        iord   = 1'b1;
        if (memrdy) state_nxt = MEMWB;
      end
      MEMWB: begin
        regwrite  = 1'b1;
        wdsel     = 2'b01;
        state_nxt = FETCH;
      end
      MEMWR: begin
        memreq   = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
        if (memrdy) state_nxt = FETCH;
      end
      RTYPEEX: begin
        alusrca   = 1'b1;
        aluop     = 3'b010;
        state_nxt = RTYPEWB;
      end
      RTYPEWB: begin
        regwrite  = 1'b1;
        regdst    = 2'b01;
        state_nxt = FETCH;
      end
      BEQEX, BNEEX: begin
        alusrca   = 1'b1;
        aluop     = 3'b001;
        pcsrc     = 2'b01;
        pcen      = (state == BEQEX) ? zero : ~zero;
        state_nxt = FETCH;
      end
      ADDIEX, ANDIEX, ORIEX: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        zeroext   = (state != ADDIEX);
        aluop     = (state == ADDIEX) ? 3'b000 : (state == ANDIEX) ? 3'b011 : 3'b100;
        state_nxt = IMMWB;
      end
      IMMWB: begin
        regwrite  = 1'b1;
        state_nxt = FETCH;
      end
      JEX: begin
        pcen      = 1'b1;
        pcsrc     = 2'b10;
        state_nxt = FETCH;
      end
      JALEX: begin
        pcen      = 1'b1;
        pcsrc     = 2'b10;
        regwrite  = 1'b1;
        regdst    = 2'b10;
        wdsel     = 2'b10;
        state_nxt = FETCH;
      end
      HALT: state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

endmodule
